instr_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the instruction ROM and feeds the decoder. It owns the PC and drives the ROM word address. It captures the combinational ROM output into a small fetch queue and presents {pc, instr} to decode through a valid/ready handshake. Execute can redirect the PC (branch or jump), which flushes the queue.

---
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, and buffers
// {pc, instr, oob} in a small queue presented to decode via valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned IMEM_WORDS  = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_oob,
    output logic        fetch_fault
);

    localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [31:0] q_pc    [QUEUE_DEPTH];
    logic [31:0] q_instr [QUEUE_DEPTH];
    logic        q_oob   [QUEUE_DEPTH];

    logic        pop;
    logic        push;
    logic        fetch_oob;
    logic [31:0] fetch_word;

    // Handshake and fetch decisions; an out-of-range fetch never looks at the ROM.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        fetch_oob  = 1'b0;
        fetch_word = imem_instr;

        pop        = out_valid & out_ready;
        push       = ((count < FULL_CNT) | pop) & ~fetch_fault & ~redirect_valid;
        fetch_oob  = (pc >= IMEM_LIMIT);
        if (fetch_oob) begin
            fetch_word = NOP_INSTR;
        end
    end

    // PC, queue pointers/occupancy and storage; redirect overrides push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_fault <= 1'b0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
                q_oob[i]   <= 1'b0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_fault <= 1'b1;
            end
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= fetch_word;
                q_oob[wr_ptr]   <= fetch_oob;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                pc              <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = q_pc[rd_ptr];
    assign out_instr = q_instr[rd_ptr];
    assign out_oob   = q_oob[rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned WORDS      = 32;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oob;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_oob;
    logic        fetch_fault;

    logic [31:0] rom [WORDS];

    // Model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_fault;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_oob(out_oob), .fetch_fault(fetch_fault)
    );

    // ROM aliases out-of-range addresses so a DUT that reads it there is caught.
    assign imem_instr = rom[imem_addr[6:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (!rst) begin
            m_pc    = RESET_PC;
            m_fault = 1'b0;
            mq.delete();
        end else if (rv) begin
            mq.delete();
            if (rpc % 4 != 0) m_fault = 1'b1;
            m_pc = rpc - (rpc % 4);
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = ((mq.size() < DEPTH) || do_pop) && !m_fault;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc    = m_pc;
                e.oob   = (m_pc >= WORDS * 4);
                e.instr = e.oob ? NOP : rom[m_pc / 4];
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        check("valid", 32'(out_valid), 32'(mq.size() > 0));
        check("imem_addr", imem_addr, m_pc);
        check("fault", 32'(fetch_fault), 32'(m_fault));
        if (mq.size() > 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
            check("out_oob", 32'(out_oob), 32'(mq[0].oob));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic rdy);
        rst_n          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_step(rst, rv, rpc, rdy);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rv;
        logic        rst;
        int unsigned sel;

        for (int i = 0; i < WORDS; i++) rom[i] = $urandom();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        m_pc = RESET_PC; m_fault = 1'b0;

        // Reset state, storage cleared
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_oob", 32'(out_oob), 32'h0);

        // Streaming with ready held: 0,4,8,12 without bubbles
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_pc", out_pc, 32'(i * 4));
            check("stream_instr", out_instr, rom[i]);
        end

        // Backpressure: queue fills, pc stops at 8, head holds pc 0
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            check("bp_head_pc", out_pc, 32'h0);
        end
        check("bp_pc", imem_addr, 32'h8);
        for (int i = 1; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("bp_resume_pc", out_pc, 32'(i * 4));
        end

        // Redirect to 0x10 with a full queue
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h10, 1'b0);
        check("redir_flush", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_pc", out_pc, 32'h10);
        check("redir_instr", out_instr, rom[4]);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_pc2", out_pc, 32'h14);

        // Range boundary at 0x7C / 0x80
        step(1'b1, 1'b1, 32'h7C, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("edge_pc", out_pc, 32'h7C);
        check("edge_instr", out_instr, rom[31]);
        check("edge_oob", 32'(out_oob), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("oob_pc", out_pc, 32'h80);
        check("oob_instr", out_instr, NOP);
        check("oob_flag", 32'(out_oob), 32'h1);

        // Misaligned redirect: sticky fault until reset
        step(1'b1, 1'b1, 32'h22, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("fault_novalid", 32'(out_valid), 32'h0);
        end
        check("fault_flag", 32'(fetch_fault), 32'h1);
        check("fault_pc", imem_addr, 32'h20);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("fault_rst_pc", imem_addr, 32'h0);
        check("fault_rst_flag", 32'(fetch_fault), 32'h0);

        // Reset beats a simultaneous redirect with a full queue
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        check("rst_redir_valid", 32'(out_valid), 32'h0);
        check("rst_redir_pc", imem_addr, RESET_PC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("restart_pc", out_pc, 32'h0);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_pc", out_pc, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 39);
            if (sel == 0)      rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else if (sel == 1) rpc = 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
            else               rpc = 32'($urandom_range(0, 40) * 4);
            step(rst, rv, rpc, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
